debounce_scheduler: RTL and testbench
=====================================

Name: debounce_scheduler

Overview:
- Round-robin controller that time-shares one debounce mod-counter across NUM_BTN button inputs.
- Input is NUM_BTN already-synchronized button levels. Output is debounced levels plus one-cycle press and release pulses.
- Sits between the input synchronizers and the button-controller FSMs.
- Replaces one counter per button with a single counter plus a scan FSM.

Parameters:
- NUM_BTN, 4, number of buttons served; must be >= 2.
- DEBOUNCE_CYCLES, 50000, consecutive WAIT cycles an input must differ from its debounced level before it commits; must be >= 2.
- CNT_WIDTH, 16, width of the shared counter; 2**CNT_WIDTH >= DEBOUNCE_CYCLES.
- IDX_W (localparam), $clog2(NUM_BTN), width of the scan index.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- scan_en  in  1  when 1, the scanner may advance and start new WAITs.
- btn_sync  in  NUM_BTN  synchronized raw button levels.
- btn_level  out  NUM_BTN  debounced levels.
- press_pulse  out  NUM_BTN  one-cycle pulse when a level commits 0->1.
- release_pulse  out  NUM_BTN  one-cycle pulse when a level commits 1->0.
- busy  out  1  high while in WAIT.
- active_idx  out  IDX_W  current scan pointer.

Behaviour:
- Reset (reset_n=0, async):
  - state=SCAN, ptr=0, counter=0.
  - btn_level, press_pulse and release_pulse all 0; busy=0.
- Release of reset is synchronous to clk.
- Mismatch is defined as btn_sync[ptr] != btn_level[ptr].
- State SCAN, one index examined per cycle:
  - scan_en=0: hold ptr, stay in SCAN.
  - scan_en=1 and mismatch: go to WAIT, clear counter, keep ptr.
  - scan_en=1 and no mismatch: ptr <= (ptr==NUM_BTN-1) ? 0 : ptr+1.
- State WAIT: counter increments every cycle, starting from 0 on the first WAIT cycle. rollover = (count == DEBOUNCE_CYCLES-1).
  - No mismatch (input bounced back): abort. Go to SCAN, advance ptr, clear counter, no output change. Abort takes priority over rollover in the same cycle.
  - Mismatch and rollover: commit. btn_level[ptr] <= btn_sync[ptr], with press_pulse[ptr] or release_pulse[ptr] chosen by the new value. Then advance ptr, clear counter, go to SCAN.
  - Otherwise: stay in WAIT.
  - scan_en is ignored in WAIT; a WAIT in progress always completes or aborts.
- Latency:
  - Commit happens on the edge ending the DEBOUNCE_CYCLES-th WAIT cycle.
  - Pulses are registered and high exactly the following cycle, and only one bit per cycle.
  - WAIT entry occurs on the edge after the SCAN cycle that detects the mismatch.
- Pulses are never high for two consecutive cycles on the same bit.
- At most one button is in WAIT at a time. Other buttons' changes are seen only when ptr reaches them.
- busy = (state==WAIT), combinational from state. active_idx = ptr.
- Counter width: compare in CNT_WIDTH bits. The counter never exceeds DEBOUNCE_CYCLES-1.
- Mid-operation reset: everything returns to reset values immediately, including a pending pulse and an in-progress WAIT.

Decomposition:
- Package debounce_pkg:
  - Typedef for the state enum {SCAN, WAIT}.
  - Typedef for the btn vector.
  - Helper function next_idx(ptr, n) for wrap-around.
- Sub-module: reuse the team's existing timer mod-counter (MOD_VALUE=DEBOUNCE_CYCLES, BIT_WIDTH=CNT_WIDTH). Connections:
  - increment = (state==WAIT).
  - Its synchronous reset driven by (state!=WAIT) or abort.
  - rolling_over is the commit qualifier.
- The async active-low reset stays in the scheduler registers. The timer is cleared by the FSM the cycle after reset release, because state=SCAN holds the timer reset.

Test Plan (NUM_BTN=4, DEBOUNCE_CYCLES=8):
- Reset: reset_n=0 with btn_sync=4'b1111 -> btn_level=0, no pulses, busy=0, active_idx=0. Pulse reset_n low mid-WAIT -> same values within the same cycle.
- Clean press on btn 2 (scan_en=1, held high from reset release):
  - ptr reaches 2 on the third SCAN cycle.
  - busy high for exactly 8 cycles.
  - btn_level[2]=1; press_pulse=4'b0100 for 1 cycle; then active_idx=3.
- Glitch on btn 1: high for 5 cycles once WAIT starts, then low -> abort. No btn_level change, no pulse, busy drops, active_idx=2.
- Simultaneous rise on btn 0 and btn 3 -> btn 0 commits first. btn 3 WAIT starts 3 cycles after btn 0 commit (SCAN 1, 2, 3) and commits 8 cycles later. Pulses 4'b0001 then 4'b1000, never overlapping.
- Release on btn 2 (level 1, input drops) -> after 8 WAIT cycles btn_level[2]=0 and release_pulse=4'b0100 for 1 cycle.
- scan_en=0 with mismatch on btn 1 (ptr=1) -> ptr frozen, no WAIT. Raise scan_en -> WAIT begins next edge. Drop scan_en mid-WAIT -> WAIT still commits after 8 cycles.

Source files
------------

// File: rtl/debounce_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and helpers for the time-shared button debouncer.
//   state_t   : scan FSM states (SCAN examines one button per cycle,
//               WAIT times a single button's mismatch).
//   btn_vec_t : generic button vector, wide enough for any supported count.
//   next_idx  : wrap-around increment of the scan pointer.
// -----------------------------------------------------------------------------
package debounce_pkg;

   typedef enum logic {
      SCAN = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int MAX_BTN = 32;

   typedef logic [MAX_BTN-1:0] btn_vec_t;

   // Next scan index, wrapping from n-1 back to 0.
   function automatic int next_idx(input int ptr, input int n);
      return (ptr == n - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/debounce_scheduler_if.sv
// -----------------------------------------------------------------------------
// debounce_scheduler_if
// Groups the debouncer's data signals.
//   scan_en       : allow the scanner to advance / start new WAITs
//   btn_sync      : synchronized raw button levels
//   btn_level     : debounced levels
//   press_pulse   : one-cycle pulse on a committed 0->1
//   release_pulse : one-cycle pulse on a committed 1->0
//   busy          : high while a button is being timed
//   active_idx    : current scan pointer
// master = stimulus side (drives scan_en/btn_sync), slave = debouncer.
// -----------------------------------------------------------------------------
interface debounce_scheduler_if #(
   parameter int NUM_BTN = 4
) ();
   localparam int IDX_W = $clog2(NUM_BTN);

   logic               scan_en;
   logic [NUM_BTN-1:0] btn_sync;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] press_pulse;
   logic [NUM_BTN-1:0] release_pulse;
   logic               busy;
   logic [IDX_W-1:0]   active_idx;

   modport master (
      output scan_en, btn_sync,
      input  btn_level, press_pulse, release_pulse, busy, active_idx
   );

   modport slave (
      input  scan_en, btn_sync,
      output btn_level, press_pulse, release_pulse, busy, active_idx
   );
endinterface

// File: rtl/debounce_scheduler_timer.sv
// -----------------------------------------------------------------------------
// debounce_scheduler_timer
// Mod-MOD_VALUE counter with synchronous clear.
//   clk            : clock
//   srst_i         : synchronous clear (wins over increment)
//   increment_i    : advance the count this cycle
//   rolling_over_o : count is at MOD_VALUE-1 (terminal value)
// -----------------------------------------------------------------------------
module debounce_scheduler_timer #(
   parameter int MOD_VALUE = 50000,
   parameter int BIT_WIDTH = 16
) (
   input  logic clk,
   input  logic srst_i,
   input  logic increment_i,
   output logic rolling_over_o
);
   logic [BIT_WIDTH-1:0] count_q;

   assign rolling_over_o = (count_q == BIT_WIDTH'(MOD_VALUE - 1));

   always_ff @(posedge clk) begin
      if (srst_i) begin
         count_q <= '0;
      end else if (increment_i) begin
         count_q <= rolling_over_o ? '0 : count_q + 1'b1;
      end
   end
endmodule

// File: rtl/debounce_scheduler.sv
// -----------------------------------------------------------------------------
// debounce_scheduler
// Round-robin debouncer: one shared mod-counter serves NUM_BTN buttons.
// A scan FSM looks at one button per cycle; on a mismatch between the raw
// and debounced level it parks on that button and times it. The level
// commits after DEBOUNCE_CYCLES consecutive mismatching WAIT cycles.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : debounce_scheduler_if.slave (scan_en, btn_sync in;
//             btn_level, press/release pulses, busy, active_idx out)
// -----------------------------------------------------------------------------
module debounce_scheduler
   import debounce_pkg::*;
#(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   debounce_scheduler_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_BTN);

   state_t             state_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   ptr_d;
   logic [NUM_BTN-1:0] level_q;
   logic [NUM_BTN-1:0] press_q;
   logic [NUM_BTN-1:0] release_q;
   logic [NUM_BTN-1:0] mismatch_vec;
   logic               mismatch;
   logic               in_wait;
   logic               abort;
   logic               timer_srst;
   logic               rolling_over;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTN; gi++) begin : g_mismatch
         assign mismatch_vec[gi] = bus.btn_sync[gi] ^ level_q[gi];
      end
   endgenerate

   assign mismatch = mismatch_vec[ptr_q];
   assign in_wait  = (state_q == WAIT);
   // Input bounced back to its debounced level: drop this WAIT.
   assign abort    = in_wait && !mismatch;
   assign ptr_d    = IDX_W'(next_idx(int'(ptr_q), NUM_BTN));

   // Timer held clear outside WAIT, so every WAIT starts counting from 0.
   assign timer_srst = !in_wait || abort;

   debounce_scheduler_timer #(
      .MOD_VALUE (DEBOUNCE_CYCLES),
      .BIT_WIDTH (CNT_WIDTH)
   ) u_timer (
      .clk            (clk),
      .srst_i         (timer_srst),
      .increment_i    (in_wait),
      .rolling_over_o (rolling_over)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= SCAN;
         ptr_q     <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
      end else begin
         // Pulses live for exactly one cycle after a commit.
         press_q   <= '0;
         release_q <= '0;
         case (state_q)
            SCAN: begin
               if (bus.scan_en) begin
                  if (mismatch) begin
                     state_q <= WAIT;
                  end else begin
                     ptr_q <= ptr_d;
                  end
               end
            end
            WAIT: begin
               // Abort is checked first so it wins over a same-cycle rollover.
               if (abort) begin
                  state_q <= SCAN;
                  ptr_q   <= ptr_d;
               end else if (rolling_over) begin
                  level_q[ptr_q] <= bus.btn_sync[ptr_q];
                  if (bus.btn_sync[ptr_q]) begin
                     press_q[ptr_q] <= 1'b1;
                  end else begin
                     release_q[ptr_q] <= 1'b1;
                  end
                  state_q <= SCAN;
                  ptr_q   <= ptr_d;
               end
            end
            default: state_q <= SCAN;
         endcase
      end
   end

   assign bus.btn_level     = level_q;
   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.busy          = in_wait;
   assign bus.active_idx    = ptr_q;
endmodule

// File: tb/tb_debounce_scheduler.sv
module tb_debounce_scheduler;
   logic clk;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   // Expected pulse events, {press_pulse, release_pulse}, in commit order.
   logic [7:0] exp_q[$];

   debounce_scheduler_if #(.NUM_BTN(4)) bus ();

   debounce_scheduler #(
      .NUM_BTN         (4),
      .DEBOUNCE_CYCLES (8),
      .CNT_WIDTH       (16)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] lvl, input logic bsy,
                          input logic [1:0] idx, input logic [3:0] pr, input logic [3:0] rl);
      chk({tag, "/level"}, 32'(bus.btn_level), 32'(lvl));
      chk({tag, "/busy"}, 32'(bus.busy), 32'(bsy));
      chk({tag, "/idx"}, 32'(bus.active_idx), 32'(idx));
      chk({tag, "/press"}, 32'(bus.press_pulse), 32'(pr));
      chk({tag, "/release"}, 32'(bus.release_pulse), 32'(rl));
      $display("step %s: level=%b busy=%b idx=%0d press=%b release=%b",
               tag, bus.btn_level, bus.busy, bus.active_idx, bus.press_pulse, bus.release_pulse);
   endtask

   // Scoreboard: every observed pulse must match the next expected event.
   always @(negedge clk) begin
      if (reset_n && (bus.press_pulse != 4'b0 || bus.release_pulse != 4'b0)) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_pulse", 32'({bus.press_pulse, bus.release_pulse}), 32'h0);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("sb_pulse", 32'({bus.press_pulse, bus.release_pulse}), 32'(e));
            $display("sb pulse: press=%b release=%b", bus.press_pulse, bus.release_pulse);
         end
      end
   end

   initial begin
      reset_n      = 1'b0;
      bus.scan_en  = 1'b0;
      bus.btn_sync = 4'b1111;
      repeat (3) @(negedge clk);
      chk_all("reset", 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000);

      // Clean press on btn 2, scan_en high from reset release.
      bus.btn_sync = 4'b0100;
      bus.scan_en  = 1'b1;
      exp_q.push_back({4'b0100, 4'b0000});
      reset_n = 1'b1;
      @(negedge clk); chk_all("press2_scan1", 4'b0000, 1'b0, 2'd1, 4'b0, 4'b0);
      @(negedge clk); chk_all("press2_scan2", 4'b0000, 1'b0, 2'd2, 4'b0, 4'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); chk_all($sformatf("press2_wait%0d", i), 4'b0000, 1'b1, 2'd2, 4'b0, 4'b0);
      end
      @(negedge clk); chk_all("press2_commit", 4'b0100, 1'b0, 2'd3, 4'b0100, 4'b0);
      @(negedge clk); chk_all("press2_after", 4'b0100, 1'b0, 2'd0, 4'b0, 4'b0);

      // Glitch on btn 1: high through 5 WAIT edges, then back low.
      bus.btn_sync = 4'b0110;
      @(negedge clk); chk_all("glitch_scan", 4'b0100, 1'b0, 2'd1, 4'b0, 4'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); chk_all($sformatf("glitch_wait%0d", i), 4'b0100, 1'b1, 2'd1, 4'b0, 4'b0);
      end
      bus.btn_sync = 4'b0100;
      @(negedge clk); chk_all("glitch_abort", 4'b0100, 1'b0, 2'd2, 4'b0, 4'b0);
      @(negedge clk); chk_all("walk_idx3", 4'b0100, 1'b0, 2'd3, 4'b0, 4'b0);
      @(negedge clk); chk_all("walk_idx0", 4'b0100, 1'b0, 2'd0, 4'b0, 4'b0);

      // Simultaneous rise on btn 0 and btn 3.
      bus.btn_sync = 4'b1101;
      exp_q.push_back({4'b0001, 4'b0000});
      exp_q.push_back({4'b1000, 4'b0000});
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); chk_all($sformatf("dual_b0_wait%0d", i), 4'b0100, 1'b1, 2'd0, 4'b0, 4'b0);
      end
      @(negedge clk); chk_all("dual_b0_commit", 4'b0101, 1'b0, 2'd1, 4'b0001, 4'b0);
      @(negedge clk); chk_all("dual_scan2", 4'b0101, 1'b0, 2'd2, 4'b0, 4'b0);
      @(negedge clk); chk_all("dual_scan3", 4'b0101, 1'b0, 2'd3, 4'b0, 4'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); chk_all($sformatf("dual_b3_wait%0d", i), 4'b0101, 1'b1, 2'd3, 4'b0, 4'b0);
      end
      @(negedge clk); chk_all("dual_b3_commit", 4'b1101, 1'b0, 2'd0, 4'b1000, 4'b0);

      // Release on btn 2.
      bus.btn_sync = 4'b1001;
      exp_q.push_back({4'b0000, 4'b0100});
      @(negedge clk); chk_all("rel2_scan1", 4'b1101, 1'b0, 2'd1, 4'b0, 4'b0);
      @(negedge clk); chk_all("rel2_scan2", 4'b1101, 1'b0, 2'd2, 4'b0, 4'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); chk_all($sformatf("rel2_wait%0d", i), 4'b1101, 1'b1, 2'd2, 4'b0, 4'b0);
      end
      @(negedge clk); chk_all("rel2_commit", 4'b1001, 1'b0, 2'd3, 4'b0, 4'b0100);
      @(negedge clk); chk_all("rel2_after", 4'b1001, 1'b0, 2'd0, 4'b0, 4'b0);

      // scan_en gating with a mismatch on btn 1.
      @(negedge clk); chk_all("gate_idx1", 4'b1001, 1'b0, 2'd1, 4'b0, 4'b0);
      bus.scan_en  = 1'b0;
      bus.btn_sync = 4'b1011;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk_all($sformatf("gate_frozen%0d", i), 4'b1001, 1'b0, 2'd1, 4'b0, 4'b0);
      end
      bus.scan_en = 1'b1;
      exp_q.push_back({4'b0010, 4'b0000});
      @(negedge clk); chk_all("gate_wait0", 4'b1001, 1'b1, 2'd1, 4'b0, 4'b0);
      bus.scan_en = 1'b0;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk); chk_all($sformatf("gate_wait%0d", i), 4'b1001, 1'b1, 2'd1, 4'b0, 4'b0);
      end
      @(negedge clk); chk_all("gate_commit", 4'b1011, 1'b0, 2'd2, 4'b0010, 4'b0);
      @(negedge clk); chk_all("gate_hold", 4'b1011, 1'b0, 2'd2, 4'b0, 4'b0);

      // Asynchronous reset in the middle of a WAIT on btn 3.
      bus.scan_en  = 1'b1;
      bus.btn_sync = 4'b0000;
      @(negedge clk); chk_all("mid_scan", 4'b1011, 1'b0, 2'd3, 4'b0, 4'b0);
      @(negedge clk); chk_all("mid_wait0", 4'b1011, 1'b1, 2'd3, 4'b0, 4'b0);
      @(negedge clk); chk_all("mid_wait1", 4'b1011, 1'b1, 2'd3, 4'b0, 4'b0);
      reset_n = 1'b0;
      #1;
      chk_all("mid_reset", 4'b0000, 1'b0, 2'd0, 4'b0, 4'b0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk_all("post_reset_idle", 4'b0000, 1'b0, 2'd0, 4'b0, 4'b0);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
